lsu_mem_master: RTL and testbench
=================================

// Module: lsu_mem_master
// PURPOSE
//  Initiator side of the DPI-C memory port: LSU/MEM-stage bridge that accepts one load/store
//  at a time from the pipeline over valid/ready, drives rd_*/we_* of the memory model, and
//  returns load data (sign/zero-extended) or store completion over a response handshake.
//  Memory rd_data is combinational (same-cycle); writes are one-cycle we_en pulses.
// PARAMETERS
//  ADDR_W   64   address width (byte address)
//  DATA_W   64   data width; fixed 64, masks are 8 bits
// PORTS
//  clock       in   1       single clock, rising edge
//  reset_n     in   1       asynchronous, active-low reset
//  req_valid   in   1       pipeline request valid
//  req_ready   out  1       request accepted when valid&ready
//  req_wen     in   1       1=store, 0=load
//  req_size    in   2       0=B,1=H,2=W,3=D
//  req_signed  in   1       load sign-extend (ignored for stores, size 3)
//  req_addr    in   ADDR_W  byte address
//  req_wdata   in   DATA_W  store data, right-justified
//  resp_valid  out  1       response valid
//  resp_ready  in   1       response consumed when valid&ready
//  resp_rdata  out  DATA_W  extended load data; 0 for stores
//  resp_err    out  1       misaligned access flagged (only with macro)
//  rd_en       out  1       memory read enable
//  rd_addr     out  ADDR_W  memory read address; 0 when rd_en=0
//  rd_data     in   DATA_W  8 bytes from rd_addr, valid same cycle
//  we_en       out  1       memory write enable, one-cycle pulse per store
//  we_addr     out  ADDR_W  byte address
//  we_data     out  DATA_W  right-justified store data
//  we_mask     out  8       only 8'h01/8'h03/8'h0F/8'hFF, from size
// BEHAVIOUR
//  - Reset (async, reset_n=0): state IDLE; req_ready=1; resp_valid, rd_en, we_en, resp_err=0;
//    all addr/data/mask/rdata outputs 0. Reset mid-access aborts it; no retry, no partial write.
//  - FSM IDLE -> ACC -> RESP. Handshake on req_valid&req_ready latches wen/size/signed/addr/wdata.
//  - ACC (1 cycle): load: rd_en=1, rd_addr=latched addr, rd_data sampled into result reg at end
//    of cycle. Store: we_en=1 for exactly this cycle, we_mask from size; we_addr/we_data latched.
//  - RESP: resp_valid=1, outputs stable until resp_ready. Latency: accept at T -> resp_valid at T+2.
//  - req_ready = (state==IDLE) | (state==RESP & resp_ready): back-to-back accept on release cycle,
//    next ACC immediately follows; one request outstanding max; throughput 1 per 2 cycles.
//  - Load extension: take rd_data[8<<size-1:0]; extend by bit MSB if req_signed else zero; size 3 raw.
//  - resp_valid held with resp_ready=0 indefinitely; req_ready=0 meanwhile; no memory activity.
//  - Store response: resp_rdata=0. rd_en never asserted together with we_en.
// CONFIGURATION
//  LSU_MISALIGN_CHECK_EN defined: if addr mod (1<<size) != 0, ACC is skipped (no rd_en/we_en),
//   go straight to RESP with resp_err=1, resp_rdata=0; latency T+1.
//  Undefined: no check, resp_err tied 0, misaligned accesses issued unchanged to memory.
// STRUCTURE
//  Package lsu_pkg: typedef enum {IDLE,ACC,RESP} lsu_state_e; typedef size enum (SZ_B..SZ_D);
//   function size2mask(size)->8-bit mask; function load_ext(data,size,signed)->64-bit.
//  Sub-module: lsu_load_ext (combinational extend unit) — the only natural split; FSM stays top.
// TESTING
//  1 Store D addr 0x8000_0000 wdata 0x1122334455667788 -> one we_en pulse, mask 8'hFF, resp T+2 rdata 0.
//  2 Load B signed addr 0x8000_0000 after mem byte 0x88 -> resp_rdata 0xFFFF_FFFF_FFFF_FF88;
//    unsigned -> 0x0000_0000_0000_0088; load H/W mask/extend likewise (mask 8'h03/8'h0F).
//  3 Back-to-back: req_valid held 4 requests, resp_ready=1 -> accepts every 2 cycles, in order.
//  4 Backpressure: resp_ready=0 for 5 cycles -> resp held stable, req_ready=0, no rd_en/we_en.
//  5 reset_n low during ACC of a store -> we_en drops asynchronously, IDLE, resp_valid never rises.
//  6 With LSU_MISALIGN_CHECK_EN: load W addr 0x8000_0002 -> resp_err=1 at T+1, no rd_en;
//    without macro -> rd_en issued at 0x8000_0002, resp_err=0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the LSU memory master: FSM states, access sizes,
// latched request control, store byte masks and load extension.
package lsu_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned MASK_W = 8;

    typedef enum logic [1:0] {IDLE, ACC, RESP} lsu_state_e;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} lsu_size_e;

    // Request fields still needed after the address/data have been issued
    typedef struct packed {
        logic      wen;
        lsu_size_e size;
        logic      sgn;
    } lsu_ctl_t;

    function automatic logic [MASK_W-1:0] size2mask(lsu_size_e size);
        logic [MASK_W-1:0] mask;
        mask = 8'hFF;
        case (size)
            SZ_B:    mask = 8'h01;
            SZ_H:    mask = 8'h03;
            SZ_W:    mask = 8'h0F;
            default: mask = 8'hFF;
        endcase
        return mask;
    endfunction

    function automatic logic [XLEN-1:0] load_ext(logic [XLEN-1:0] data, lsu_size_e size, logic sgn);
        logic [XLEN-1:0] res;
        res = data;
        case (size)
            SZ_B:    res = {{56{sgn & data[7]}},  data[7:0]};
            SZ_H:    res = {{48{sgn & data[15]}}, data[15:0]};
            SZ_W:    res = {{32{sgn & data[31]}}, data[31:0]};
            default: res = data;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Combinational load-data extension: selects the low 1/2/4/8 bytes of the memory
// word and sign- or zero-extends them to 64 bits.
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [XLEN-1:0] data,
    input  lsu_size_e       size,
    input  logic            sgn,
    output logic [XLEN-1:0] result_c
);

    assign result_c = load_ext(data, size, sgn);

endmodule

// File: rtl/lsu_mem_master.sv
// LSU/MEM-stage bridge: one outstanding load/store, IDLE -> ACC -> RESP.
// Optional LSU_MISALIGN_CHECK_EN flags misaligned accesses instead of issuing them.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              we_en,
    output logic [ADDR_W-1:0] we_addr,
    output logic [DATA_W-1:0] we_data,
    output logic [MASK_W-1:0] we_mask
);

    lsu_state_e        state, state_d;
    lsu_ctl_t          ctl_q, ctl_d;
    logic              rd_en_d, we_en_d, resp_valid_d, resp_err_d;
    logic [ADDR_W-1:0] rd_addr_d, we_addr_d;
    logic [DATA_W-1:0] we_data_d, resp_rdata_d, ext_c;
    logic [MASK_W-1:0] we_mask_d;
    logic              accept_c, misalign_c;

    // Ready combinationally follows resp_ready so a new request can enter on the release cycle
    assign req_ready = (state == IDLE) | ((state == RESP) & resp_ready);
    assign accept_c  = req_valid & req_ready;

`ifdef LSU_MISALIGN_CHECK_EN
    logic [2:0] align_mask_c;
    assign align_mask_c = 3'((4'd1 << req_size) - 4'd1);
    assign misalign_c   = (req_addr[2:0] & align_mask_c) != 3'd0;
`else
    assign misalign_c = 1'b0;
`endif

    lsu_load_ext u_load_ext (
        .data     (rd_data),
        .size     (ctl_q.size),
        .sgn      (ctl_q.sgn),
        .result_c (ext_c)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_d;
    end

    // Next state and next values of every registered output
    always_comb begin
        state_d      = state;
        ctl_d        = ctl_q;
        rd_en_d      = 1'b0;
        rd_addr_d    = '0;
        we_en_d      = 1'b0;
        we_addr_d    = '0;
        we_data_d    = '0;
        we_mask_d    = '0;
        resp_valid_d = resp_valid;
        resp_rdata_d = resp_rdata;
        resp_err_d   = resp_err;

        case (state)
            ACC: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_rdata_d = ctl_q.wen ? '0 : ext_c;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                end
            end
            default: ;
        endcase

        if (accept_c) begin
            ctl_d = '{wen: req_wen, size: lsu_size_e'(req_size), sgn: req_signed};
            if (misalign_c) begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b1;
                resp_rdata_d = '0;
            end else begin
                state_d   = ACC;
                rd_en_d   = ~req_wen;
                rd_addr_d = req_wen ? '0 : req_addr;
                we_en_d   = req_wen;
                we_addr_d = req_wen ? req_addr : '0;
                we_data_d = req_wen ? req_wdata : '0;
                we_mask_d = req_wen ? size2mask(lsu_size_e'(req_size)) : '0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ctl_q      <= '0;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            we_en      <= 1'b0;
            we_addr    <= '0;
            we_data    <= '0;
            we_mask    <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            ctl_q      <= ctl_d;
            rd_en      <= rd_en_d;
            rd_addr    <= rd_addr_d;
            we_en      <= we_en_d;
            we_addr    <= we_addr_d;
            we_data    <= we_data_d;
            we_mask    <= we_mask_d;
            resp_valid <= resp_valid_d;
            resp_rdata <= resp_rdata_d;
            resp_err   <= resp_err_d;
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Self-checking bench for lsu_mem_master: byte-array memory model plus a
// transaction-level reference (one request in flight, byte-wise memory image).
module tb_lsu_mem_master;

    localparam logic [63:0] BASE      = 64'h8000_0000;
    localparam int          MEM_BYTES = 80;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready, req_wen, req_signed;
    logic [1:0]  req_size;
    logic [63:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [63:0] resp_rdata;
    logic        rd_en, we_en;
    logic [63:0] rd_addr, rd_data, we_addr, we_data;
    logic [7:0]  we_mask;

    always #5 clock = ~clock;

    lsu_mem_master dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .we_en      (we_en),
        .we_addr    (we_addr),
        .we_data    (we_data),
        .we_mask    (we_mask)
    );

    // Memory model: combinational read, byte-masked write on the clock edge
    logic [7:0] mem     [MEM_BYTES];
    logic [7:0] seed    [MEM_BYTES];
    logic [7:0] ref_mem [MEM_BYTES];
    logic       load_mem;

    always_comb begin
        rd_data = '0;
        if (rd_en)
            for (int i = 0; i < 8; i++)
                if ((rd_addr + 64'(i) - BASE) < 64'(MEM_BYTES))
                    rd_data[8*i +: 8] = mem[int'(rd_addr + 64'(i) - BASE)];
    end

    always @(posedge clock) begin
        if (load_mem) begin
            for (int i = 0; i < MEM_BYTES; i++) mem[i] <= seed[i];
        end else if (we_en) begin
            for (int i = 0; i < 8; i++)
                if (we_mask[i] && (we_addr + 64'(i) - BASE) < 64'(MEM_BYTES))
                    mem[int'(we_addr + 64'(i) - BASE)] <= we_data[8*i +: 8];
        end
    end

    typedef struct {
        logic        wen;
        logic [1:0]  size;
        logic        sgn;
        logic [63:0] addr;
        logic [63:0] wdata;
    } req_t;

    req_t        reqq[$];
    req_t        p, o;
    logic        p_valid, o_busy, o_err, gaps;
    int          o_acc, o_lat, cyc, n_done;
    logic [63:0] o_rdata, last_rdata;
    logic        last_err;
    int          acc_cycles[$];
    int          n_checks, n_pass;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Load value from the reference image, extended with plain arithmetic
    function automatic logic [63:0] ref_load(input req_t r);
        int          nb;
        logic [63:0] val;
        nb  = 1 << int'(r.size);
        val = '0;
        for (int i = 0; i < nb; i++)
            val |= 64'(ref_mem[int'(r.addr - BASE) + i]) << (8 * i);
        if (r.sgn && r.size != 2'd3 && val[8*nb-1])
            val |= ~((64'd1 << (8 * nb)) - 64'd1);
        return val;
    endfunction

    function automatic req_t mk(input logic wen, input logic [1:0] size, input logic sgn,
                                input logic [63:0] addr, input logic [63:0] wdata);
        req_t r;
        r.wen = wen; r.size = size; r.sgn = sgn; r.addr = addr; r.wdata = wdata;
        return r;
    endfunction

    // One cycle: drive at the falling edge, check outputs 1 time unit later
    task automatic step(input logic rr);
        logic exp_rd, exp_we, exp_rv, exp_rr;
        int   nb;
        @(negedge clock);
        cyc++;
        if (!p_valid && reqq.size() != 0 && (!gaps || ($urandom % 3) != 0)) begin
            p = reqq.pop_front();
            p_valid = 1'b1;
        end
        req_valid  = p_valid;
        req_wen    = p.wen;
        req_size   = p.size;
        req_signed = p.sgn;
        req_addr   = p.addr;
        req_wdata  = p.wdata;
        resp_ready = rr;
        #1;
        exp_rd = o_busy && !o_err && !o.wen && (cyc == o_acc + 1);
        exp_we = o_busy && !o_err &&  o.wen && (cyc == o_acc + 1);
        check_eq("rd_en", 64'(rd_en), 64'(exp_rd));
        check_eq("we_en", 64'(we_en), 64'(exp_we));
        check_eq("rd_addr", rd_addr, exp_rd ? o.addr : 64'd0);
        if (exp_we) begin
            nb = 1 << int'(o.size);
            check_eq("we_addr", we_addr, o.addr);
            check_eq("we_data", we_data, o.wdata);
            check_eq("we_mask", 64'(we_mask), (64'd1 << nb) - 64'd1);
        end
        exp_rv = o_busy && (cyc >= o_acc + o_lat);
        check_eq("resp_valid", 64'(resp_valid), 64'(exp_rv));
        if (exp_rv) begin
            check_eq("resp_rdata", resp_rdata, o_rdata);
            check_eq("resp_err", 64'(resp_err), 64'(o_err));
        end
        exp_rr = !o_busy || (exp_rv && rr);
        check_eq("req_ready", 64'(req_ready), 64'(exp_rr));
        if (exp_rv && rr) begin
            last_rdata = resp_rdata;
            last_err   = resp_err;
            if (o.wen && !o_err)
                for (int i = 0; i < (1 << int'(o.size)); i++)
                    ref_mem[int'(o.addr - BASE) + i] = o.wdata[8*i +: 8];
            o_busy = 1'b0;
            n_done++;
        end
        if (p_valid && exp_rr && reset_n) begin
            nb = 1 << int'(p.size);
`ifdef LSU_MISALIGN_CHECK_EN
            o_err = (p.addr % 64'(nb)) != 64'd0;
`else
            o_err = 1'b0;
`endif
            o       = p;
            o_lat   = o_err ? 1 : 2;
            o_rdata = (o_err || p.wen) ? 64'd0 : ref_load(p);
            o_acc   = cyc;
            o_busy  = 1'b1;
            p_valid = 1'b0;
            acc_cycles.push_back(cyc);
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((o_busy || p_valid || reqq.size() != 0) && guard < 200) begin
            step(1'b1);
            guard++;
        end
        check_eq("drain_idle", 64'({o_busy, p_valid}), 64'd0);
    endtask

    task automatic one(input req_t r, input string tag, input logic [63:0] exp);
        reqq.push_back(r);
        drain();
        check_eq(tag, last_rdata, exp);
    endtask

    initial begin
        int guard, start_done;
        n_checks = 0; n_pass = 0; cyc = 0; n_done = 0;
        p_valid = 1'b0; o_busy = 1'b0; o_err = 1'b0; gaps = 1'b0;
        p = mk(1'b0, 2'd0, 1'b0, BASE, 64'd0);
        o = p;
        reset_n = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_size = 2'd0;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        for (int i = 0; i < MEM_BYTES; i++) begin
            seed[i]    = 8'($urandom);
            ref_mem[i] = seed[i];
        end
        load_mem = 1'b1;
        @(negedge clock);
        @(negedge clock);
        load_mem = 1'b0;
        check_eq("rst_req_ready", 64'(req_ready), 64'd1);
        check_eq("rst_resp_valid", 64'(resp_valid), 64'd0);
        check_eq("rst_rd_en", 64'(rd_en), 64'd0);
        check_eq("rst_we_en", 64'(we_en), 64'd0);
        check_eq("rst_resp_err", 64'(resp_err), 64'd0);
        check_eq("rst_resp_rdata", resp_rdata, 64'd0);
        check_eq("rst_we_mask", 64'(we_mask), 64'd0);
        check_eq("rst_we_addr", we_addr, 64'd0);
        reset_n = 1'b1;

        // Directed stores/loads with hand-computed results
        one(mk(1'b1, 2'd3, 1'b0, BASE, 64'h1122_3344_5566_7788), "store_d_rdata", 64'd0);
        one(mk(1'b0, 2'd0, 1'b1, BASE, 64'd0), "load_b_signed", 64'hFFFF_FFFF_FFFF_FF88);
        one(mk(1'b0, 2'd0, 1'b0, BASE, 64'd0), "load_b_unsigned", 64'h0000_0000_0000_0088);
        one(mk(1'b0, 2'd1, 1'b1, BASE, 64'd0), "load_h_signed", 64'h0000_0000_0000_7788);
        one(mk(1'b0, 2'd2, 1'b1, BASE + 64'd4, 64'd0), "load_w_signed", 64'h0000_0000_1122_3344);
        one(mk(1'b0, 2'd2, 1'b0, BASE, 64'd0), "load_w_unsigned", 64'h0000_0000_5566_7788);
        one(mk(1'b1, 2'd1, 1'b0, BASE + 64'd8, 64'hAAAA_0000_0000_8001), "store_h_rdata", 64'd0);
        one(mk(1'b0, 2'd1, 1'b1, BASE + 64'd8, 64'd0), "load_h_neg", 64'hFFFF_FFFF_FFFF_8001);
        one(mk(1'b0, 2'd3, 1'b1, BASE, 64'd0), "load_d_raw", 64'h1122_3344_5566_7788);

        // Back-to-back: four requests queued, resp_ready held high
        acc_cycles.delete();
        reqq.push_back(mk(1'b1, 2'd2, 1'b0, BASE + 64'd16, 64'h0000_0000_CAFE_BABE));
        reqq.push_back(mk(1'b0, 2'd2, 1'b0, BASE + 64'd16, 64'd0));
        reqq.push_back(mk(1'b0, 2'd0, 1'b1, BASE + 64'd19, 64'd0));
        reqq.push_back(mk(1'b1, 2'd0, 1'b0, BASE + 64'd20, 64'h0000_0000_0000_0055));
        drain();
        check_eq("b2b_accepts", 64'(acc_cycles.size()), 64'd4);
        for (int i = 0; i + 1 < acc_cycles.size(); i++)
            check_eq("b2b_spacing", 64'(acc_cycles[i+1] - acc_cycles[i]), 64'd2);

        // Backpressure: response held for five cycles with a second request waiting
        reqq.push_back(mk(1'b0, 2'd3, 1'b0, BASE + 64'd16, 64'd0));
        reqq.push_back(mk(1'b1, 2'd3, 1'b0, BASE + 64'd24, 64'h0102_0304_0506_0708));
        step(1'b1);
        step(1'b1);
        repeat (5) step(1'b0);
        drain();

        // Misaligned word load
        reqq.push_back(mk(1'b0, 2'd2, 1'b0, BASE + 64'd2, 64'd0));
        drain();
`ifdef LSU_MISALIGN_CHECK_EN
        check_eq("misalign_err", 64'(last_err), 64'd1);
        check_eq("misalign_rdata", last_rdata, 64'd0);
`else
        check_eq("misalign_err", 64'(last_err), 64'd0);
`endif

        // Randomized traffic with random response stalls and request gaps
        for (int k = 0; k < 250; k++) begin
            logic [1:0]  sz;
            logic [63:0] off;
            sz  = 2'($urandom);
            off = 64'($urandom_range(0, 63));
            if (($urandom % 4) != 0) off = off & ~((64'd1 << sz) - 64'd1);
            reqq.push_back(mk(1'($urandom), sz, 1'($urandom), BASE + off,
                              {32'($urandom), 32'($urandom)}));
        end
        gaps = 1'b1;
        start_done = n_done;
        guard = 0;
        while ((o_busy || p_valid || reqq.size() != 0) && guard < 5000) begin
            step(($urandom % 4) != 0);
            guard++;
        end
        gaps = 1'b0;
        check_eq("rand_completed", 64'(n_done - start_done), 64'd250);

        // Reset during the ACC cycle of a store: pulse drops, nothing written, no response
        reqq.push_back(mk(1'b1, 2'd3, 1'b0, BASE + 64'd32, 64'hDEAD_BEEF_CAFE_F00D));
        guard = 0;
        do begin
            step(1'b1);
            guard++;
        end while (!(o_busy && cyc == o_acc + 1) && guard < 10);
        check_eq("rst_mid_reached_acc", 64'(we_en), 64'd1);
        reset_n = 1'b0;
        #1;
        o_busy = 1'b0;
        check_eq("rst_mid_we_en", 64'(we_en), 64'd0);
        check_eq("rst_mid_rd_en", 64'(rd_en), 64'd0);
        check_eq("rst_mid_resp_valid", 64'(resp_valid), 64'd0);
        check_eq("rst_mid_we_mask", 64'(we_mask), 64'd0);
        repeat (2) step(1'b1);
        reset_n = 1'b1;
        repeat (3) step(1'b1);
        for (int i = 0; i < 8; i++)
            check_eq("rst_no_write", 64'(mem[32 + i]), 64'(ref_mem[32 + i]));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
